// File: rtl/sayac_serial_adder_pkg.sv
// Shared definitions for the SAYAC chunk-serial adder/subtractor.
// Holds the controller state encoding, default geometry and a geometry check.
package sayac_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_SIZE  = 16;
    localparam int DEFAULT_CHUNK = 4;

    // True when the operand width splits into whole chunks.
    function automatic bit chunk_fits(input int size, input int chunk);
        return (chunk >= 1) && (chunk <= size) && ((size % chunk) == 0);
    endfunction

endpackage

// File: rtl/sayac_chunk_adder.sv
// Combinational CHUNK-bit adder slice used once per cycle by the serial adder.
// Also reports the carry into its MSB so the caller can form signed overflow.
module sayac_chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] total;

    always_comb begin
        total = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
        s     = total[CHUNK-1:0];
        co    = total[CHUNK];
        // The MSB sum bit is x^y^carry_in, so the carry into it falls out directly.
        c_msb_in = total[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
    end

endmodule

// File: rtl/sayac_serial_adder.sv
// Multi-cycle SIZE-bit adder/subtractor processing CHUNK bits per clock, LSB first,
// with a start/done handshake; reports sum, carry-out and signed overflow.
module sayac_serial_adder
    import sayac_serial_adder_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            sub,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] sum,
    output logic            cout,
    output logic            ovf
);

    localparam int N     = SIZE / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if (!chunk_fits(SIZE, CHUNK)) begin : g_bad_geometry
            $error("sayac_serial_adder: SIZE must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t            state;
    logic [SIZE-1:0]   a_r;
    logic [SIZE-1:0]   b_r;
    logic              c_r;
    logic [IDX_W-1:0]  idx;

    logic [CHUNK-1:0]  x_chunk;
    logic [CHUNK-1:0]  y_chunk;
    logic [CHUNK-1:0]  s_chunk;
    logic              c_out;
    logic              c_msb;

    always_comb begin
        x_chunk = a_r[int'(idx) * CHUNK +: CHUNK];
        y_chunk = b_r[int'(idx) * CHUNK +: CHUNK];
    end

    sayac_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x        (x_chunk),
        .y        (y_chunk),
        .ci       (c_r),
        .s        (s_chunk),
        .co       (c_out),
        .c_msb_in (c_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is folded into the operands: a + ~b + ~cin.
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        c_r   <= sub ? ~cin : cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum[int'(idx) * CHUNK +: CHUNK] <= s_chunk;
                    c_r <= c_out;
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        cout  <= c_out;
                        ovf   <= c_msb ^ c_out;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sayac_serial_adder.sv
// Self-checking bench: directed literal cases plus random traffic compared every
// cycle against an arithmetic model of the handshake and result.
module tb_sayac_serial_adder;

    localparam int SIZE  = 16;
    localparam int CHUNK = 4;
    localparam int N     = SIZE / CHUNK;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            sub;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            cin;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] sum;
    logic            cout;
    logic            ovf;

    logic            start8;
    logic [7:0]      a8;
    logic [7:0]      b8;
    logic            busy8;
    logic            done8;
    logic [7:0]      sum8;
    logic            cout8;
    logic            ovf8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sayac_serial_adder #(.SIZE(SIZE), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    sayac_serial_adder #(.SIZE(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(1'b0), .a(a8), .b(b8), .cin(1'b0),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, cout, sum} from plain unsigned and signed arithmetic.
    function automatic logic [SIZE+1:0] model(input logic [SIZE-1:0] ia, input logic [SIZE-1:0] ib,
                                              input logic isub, input logic icin);
        logic [SIZE-1:0] bb;
        logic            cc;
        logic [SIZE:0]   full;
        longint          sv;
        logic            o;
        bb   = isub ? ~ib : ib;
        cc   = isub ? ~icin : icin;
        full = {1'b0, ia} + {1'b0, bb} + {{SIZE{1'b0}}, cc};
        sv   = longint'($signed(ia)) + longint'($signed(bb)) + longint'(cc);
        o    = (sv > 32767) || (sv < -32768);
        return {o, full[SIZE], full[SIZE-1:0]};
    endfunction

    // Cycle model: an accepted op keeps busy for N cycles, then done pulses once.
    int               cnt = 0;
    logic             e_done = 1'b0;
    logic [SIZE-1:0]  e_sum = '0;
    logic             e_cout = 1'b0;
    logic             e_ovf = 1'b0;
    logic [SIZE+1:0]  pend = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                cnt = 0; e_done = 1'b0; e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0;
            end else begin
                e_done = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        e_done = 1'b1;
                        {e_ovf, e_cout, e_sum} = pend;
                    end
                end else if (start) begin
                    pend = model(a, b, sub, cin);
                    cnt  = N;
                end
            end
            @(negedge clk);
            chk("m_busy", 32'(busy), 32'(cnt > 0));
            chk("m_done", 32'(done), 32'(e_done));
            chk("m_cout", 32'(cout), 32'(e_cout));
            chk("m_ovf",  32'(ovf),  32'(e_ovf));
            if (cnt == 0) chk("m_sum", 32'(sum), 32'(e_sum));
        end
    end

    task automatic accept(input logic [SIZE-1:0] ia, input logic [SIZE-1:0] ib,
                          input logic isub, input logic icin);
        @(negedge clk);
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the first negedge after the accept edge; cyc counts edges since accept.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic op(input logic [SIZE-1:0] ia, input logic [SIZE-1:0] ib, input logic isub,
                      input logic icin, input logic [SIZE-1:0] es, input logic ec,
                      input logic eo, input string nm);
        int cyc;
        int busy_cnt;
        accept(ia, ib, isub, icin);
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_lat"},  32'(cyc), 32'(N));
        chk({nm, "_busy"}, 32'(busy_cnt), 32'(N));
        chk({nm, "_sum"},  32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_ovf"},  32'(ovf), 32'(eo));
        @(negedge clk);
        chk({nm, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int c1;
        int c2;
        int seen;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        rst = 1'b0;

        chk("model_add", 32'(model(16'h1234, 16'h1111, 1'b0, 1'b0)), {14'd0, 2'b00, 16'h2345});
        chk("model_sub", 32'(model(16'h8000, 16'h0001, 1'b1, 1'b0)), {14'd0, 2'b11, 16'h7FFF});

        op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "add");
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
        op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        op(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, "sub_bin");

        // start and operand changes during RUN must be ignored
        accept(16'h4321, 16'h0101, 1'b0, 1'b1);
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(c1);
        chk("ign_lat", 32'(c1 + 1), 32'(N));
        chk("ign_sum", 32'(sum), 32'h4423);

        // back-to-back: start held in the DONE cycle
        accept(16'h0102, 16'h0304, 1'b0, 1'b0);
        wait_done(c1);
        chk("b2b_first", 32'(sum), 32'h0406);
        a = 16'hA000; b = 16'h6000; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c2);
        chk("b2b_gap",  32'(c2 + 1), 32'(N + 1));
        chk("b2b_sum",  32'(sum), 32'h0000);
        chk("b2b_cout", 32'(cout), 32'd1);

        // reset in the second RUN cycle abandons the op
        accept(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_sum",  32'(sum),  32'd0);
        chk("mrst_cout", 32'(cout), 32'd0);
        chk("mrst_ovf",  32'(ovf),  32'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("mrst_nodone", 32'(seen), 32'd0);
        op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "after_rst");

        // single-chunk instance
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("n1_busy", 32'(busy8), 32'd1);
        chk("n1_early", 32'(done8), 32'd0);
        @(negedge clk);
        chk("n1_done", 32'(done8), 32'd1);
        chk("n1_sum",  32'(sum8),  32'h00);
        chk("n1_cout", 32'(cout8), 32'd1);
        chk("n1_ovf",  32'(ovf8),  32'd1);

        // random traffic, checked by the cycle model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            sub   = 1'($urandom);
            cin   = 1'($urandom);
            a     = 16'($urandom);
            b     = 16'($urandom);
            rst   = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (N + 3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sayac_serial_adder.md
Name: sayac_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor for the SAYAC datapath.
- Adds or subtracts two SIZE-bit operands, CHUNK bits per clock, LSB chunk first, with a registered carry between chunks.
- Trades latency for area in wide arithmetic (address and multi-precision ops).
- Start/done handshake; produces sum, carry-out and signed overflow.

Parameters:
- SIZE, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per clock; 1 <= CHUNK <= SIZE.
- N (localparam), SIZE/CHUNK, number of compute cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE or DONE
- sub  in  1  0 = a+b+cin; 1 = a-b-cin
- a  in  SIZE  operand A, sampled at accept
- b  in  SIZE  operand B, sampled at accept
- cin  in  1  carry-in (add) / borrow-in (sub), sampled at accept
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse: result valid
- sum  out  SIZE  result
- cout  out  1  carry out of MSB; for sub, 1 = no borrow
- ovf  out  1  signed overflow (two's complement)

Behaviour:
- Reset (synchronous; rst high at a rising edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal chunk index and carry cleared.
  - rst has priority over all other inputs, including mid-RUN. The in-flight operation is abandoned with no done pulse.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch a_r=a, b_r=(sub ? ~b : b), c_r=(sub ? ~cin : cin); clear idx; go RUN.
  - RUN: each edge adds chunk idx, {c, s} = a_r[idx] + b_r[idx] + c_r. s is written into sum chunk idx and c into c_r. idx increments.
    - After chunk N-1: cout=c; ovf = (carry into MSB) XOR c, captured in the final cycle; go DONE.
  - DONE: done=1 for exactly one cycle.
    - start=1 -> accept new operands as in IDLE, go RUN (back-to-back).
    - start=0 -> go IDLE.
- Latency: the accept edge is E0. Chunk k is computed at edge E(k+1), so done is high in the cycle after edge EN. With defaults, done is high 4 cycles after the accept edge; throughput is one result per N+1 cycles.
- start while in RUN is ignored, with no queuing. a, b, sub and cin may change freely during RUN.
- Output timing:
  - sum is updated chunk by chunk during RUN. Only its value while done=1 is defined as the result.
  - sum, cout and ovf hold after DONE until the next accepted operation's first RUN edge. cout and ovf change only at the last RUN edge.
- Arithmetic:
  - Unsigned modulo 2^SIZE; cout is the (SIZE+1)th bit.
  - For sub, the result is a + ~b + ~cin, i.e. a - b - cin.
  - ovf is defined for both modes.
- CHUNK==SIZE (N=1) is legal; done is high 1 cycle after the accept edge.

Decomposition:
- Shared package:
  - state encoding (IDLE/RUN/DONE)
  - default SIZE/CHUNK constants
  - a SIZE % CHUNK == 0 elaboration check
- Sub-module: sayac_chunk_adder #(CHUNK), purely combinational.
  - Inputs: x, y, ci. Outputs: s, co, c_msb_in (carry into its MSB, used for ovf).
  - One instance in the datapath, muxed by idx.
- Top level: FSM, index counter, operand/carry registers.

Test Plan:
- SIZE=16, CHUNK=4: a=0x1234, b=0x1111, sub=0, cin=0, start -> done 4 cycles after accept; sum=0x2345, cout=0, ovf=0; busy high for exactly 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 chunks). a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- sub=1: a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1. a=0x0010, b=0x0001, cin=1 -> sum=0x000E, cout=1.
- Pulse start and change a/b during RUN -> ignored; result matches operands at accept. start held high in the DONE cycle -> next op accepted, second done exactly 5 cycles after the first.
- Assert rst for one cycle at the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0, no done pulse. A fresh op then gives the correct result (a=0x00FF, b=0x0001 -> 0x0100).
- SIZE=8, CHUNK=8: a=0x80, b=0x80 -> done 1 cycle after accept; sum=0x00, cout=1, ovf=1.
